present80_dec: RTL and testbench

- Iterative PRESENT-80 decryption core: the decrypt counterpart to the existing PRESENT encryption datapath and its forward S-box.
- Accepts a 64-bit ciphertext and an 80-bit master key, and returns the 64-bit plaintext.
- First runs the forward key schedule to derive K32, then unwinds 31 rounds: inverse pLayer, inverse S-box, and a reverse key schedule.
- Sits beside the encrypt core in the crypto peripheral; one block in flight at a time.

---
 rtl/present80_dec.sv | 176 +++++++++++++++++
 tb/tb_present80_dec.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryption core: forward key expansion to K32, then 31 inverse rounds.
// Optional PRESENT_KEY_CACHE_EN keeps the last expanded key so repeated keys skip KEYEXP.
module present80_dec #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [79:0] key_i,
    input  logic [63:0] ct_i,
    output logic        ready_o,
    output logic [63:0] pt_o,
    output logic        done_o
);

    // state    | meaning
    // S_IDLE   | waiting for start_i, ready_o high
    // S_KEYEXP | forward key schedule, rc = 1..ROUNDS
    // S_DEC    | inverse rounds with reverse key schedule, rc = ROUNDS..1
    // S_FIN    | final key whitening, pt_o/done_o update
    typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_DEC, S_FIN} state_t;

    localparam logic [4:0] RC_LAST = 5'(ROUNDS);

    state_t      state_q, state_d;
    logic [63:0] st_q, st_d;
    logic [79:0] kr_q, kr_d;
    logic [4:0]  rc_q, rc_d;
    logic [63:0] pt_q, pt_d;
    logic        done_q, done_d;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[60 - 4*int'(x) +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h5EF8C12DB463079A;
        return tbl[60 - 4*int'(x) +: 4];
    endfunction

    function automatic logic [63:0] sinv_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] pinv(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) y[(4*j) % 63] = x[j];
        y[63] = x[63];
        return y;
    endfunction

    logic [79:0] kexp_rot, kexp, krev_x, krev_s, krev;

    always_comb begin
        kexp_rot = {kr_q[18:0], kr_q[79:19]};
        kexp     = {sbox_fwd(kexp_rot[79:76]), kexp_rot[75:20],
                    kexp_rot[19:15] ^ rc_q, kexp_rot[14:0]};
        // Reverse step undoes the forward one in opposite order: xor, Sinv, rotate right 61.
        krev_x   = {kr_q[79:20], kr_q[19:15] ^ rc_q, kr_q[14:0]};
        krev_s   = {sbox_inv(krev_x[79:76]), krev_x[75:0]};
        krev     = {krev_s[60:0], krev_s[79:61]};
    end

    logic        cache_hit;
    logic [79:0] cache_k32;

`ifdef PRESENT_KEY_CACHE_EN
    logic        cache_vld_q, cache_vld_d;
    logic [79:0] cache_key_q, cache_key_d;
    logic [79:0] cache_k32_q, cache_k32_d;

    assign cache_hit = cache_vld_q && (key_i == cache_key_q);
    assign cache_k32 = cache_k32_q;

    // Invalidate at KEYEXP entry so an aborted expansion never leaves a stale entry.
    always_comb begin
        cache_vld_d = cache_vld_q;
        cache_key_d = cache_key_q;
        cache_k32_d = cache_k32_q;
        if (state_q == S_IDLE && start_i && !cache_hit) begin
            cache_vld_d = 1'b0;
            cache_key_d = key_i;
        end
        if (state_q == S_KEYEXP && rc_q == RC_LAST) begin
            cache_vld_d = 1'b1;
            cache_k32_d = kexp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_k32_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_key_q <= cache_key_d;
            cache_k32_q <= cache_k32_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_k32 = '0;
`endif

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        kr_d    = kr_q;
        rc_d    = rc_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    st_d = ct_i;
                    if (cache_hit) begin
                        kr_d    = cache_k32;
                        rc_d    = RC_LAST;
                        state_d = S_DEC;
                    end else begin
                        kr_d    = key_i;
                        rc_d    = 5'd1;
                        state_d = S_KEYEXP;
                    end
                end
            end
            S_KEYEXP: begin
                kr_d = kexp;
                if (rc_q == RC_LAST) state_d = S_DEC;
                else                 rc_d    = rc_q + 5'd1;
            end
            S_DEC: begin
                st_d = sinv_layer(pinv(st_q ^ kr_q[79:16]));
                kr_d = krev;
                rc_d = rc_q - 5'd1;
                if (rc_q == 5'd1) state_d = S_FIN;
            end
            S_FIN: begin
                pt_d    = st_q ^ kr_q[79:16];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            kr_q    <= '0;
            rc_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            kr_q    <= kr_d;
            rc_q    <= rc_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign pt_o    = pt_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_present80_dec.sv
// Bench for present80_dec: known-answer vectors plus random blocks checked against a
// PRESENT-80 encryption model (ciphertext generated from a random plaintext).
module tb_present80_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [79:0] key_i;
    logic [63:0] ct_i;
    logic        ready_o;
    logic [63:0] pt_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam int FULL_LAT   = 63;
    localparam int CACHED_LAT = 32;

    logic        m_vld = 1'b0;
    logic [79:0] m_key = '0;

    present80_dec #(.ROUNDS(31)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .key_i   (key_i),
        .ct_i    (ct_i),
        .ready_o (ready_o),
        .pt_o    (pt_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] present_enc(input logic [63:0] p, input logic [79:0] k0);
        logic [63:0] sb, s, t, u;
        logic [79:0] k;
        int pos;
        sb = 64'hC56B90AD3EF84712;
        k  = k0;
        s  = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = sb[60 - 4*int'(s[4*n +: 4]) +: 4];
            for (int i = 0; i < 64; i++) begin
                pos = (i == 63) ? 63 : (16*i) % 63;
                u[pos] = t[i];
            end
            s = u;
            k = {k[18:0], k[79:19]};
            k[79:76] = sb[60 - 4*int'(k[79:76]) +: 4];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    function automatic int exp_lat(input logic [79:0] k);
`ifdef PRESENT_KEY_CACHE_EN
        if (m_vld && k == m_key) return CACHED_LAT;
`endif
        return FULL_LAT;
    endfunction

    function automatic logic [79:0] rand_key();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    function automatic logic [63:0] rand_64();
        return {$urandom(), $urandom()};
    endfunction

    // Starts one block, waits for done_o and checks latency, result, ready_o and pulse width.
    task automatic run_block(input string tag, input logic [79:0] k, input logic [63:0] ct,
                             input logic [63:0] exp_pt);
        int lat, n;
        logic rdy_ok;
        lat = exp_lat(k);
        chk({tag, ".ready_idle"}, 80'(ready_o), 80'(1));
        key_i = k; ct_i = ct; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 0;
        rdy_ok = 1'b1;
        while (done_o !== 1'b1 && n < 200) begin
            if (ready_o !== 1'b0) rdy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 80'(n), 80'(lat));
        chk({tag, ".pt"}, 80'(pt_o), 80'(exp_pt));
        chk({tag, ".ready_low"}, 80'(rdy_ok), 80'(1));
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 80'(done_o), 80'(0));
        chk({tag, ".pt_hold"}, 80'(pt_o), 80'(exp_pt));
        m_vld = 1'b1;
        m_key = k;
    endtask

    initial begin
        logic [79:0] ka, kb, kr;
        logic [63:0] pa, pb, pr, ca, cb, cr;
        logic [63:0] pt_cap;
        int n_done, done_at, c, latb;
        logic acc;

        rst = 1'b1; start_i = 1'b0; key_i = '0; ct_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 80'(ready_o), 80'(1));
        chk("rst.done", 80'(done_o), 80'(0));
        chk("rst.pt", 80'(pt_o), 80'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_block("kat0", 80'h0, 64'h5579C1387B228445, 64'h0);
        run_block("kat1", {80{1'b1}}, 64'hE72C46C0F5945049, 64'h0);
        run_block("kat2", 80'h0, 64'hA112FFC72F68417B, {64{1'b1}});
        run_block("kat3", {80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});
        run_block("b2b0", 80'h0, 64'h5579C1387B228445, 64'h0);
        run_block("b2b1", 80'h0, 64'hA112FFC72F68417B, {64{1'b1}});
        run_block("b2b2", {80{1'b1}}, 64'hE72C46C0F5945049, 64'h0);

        // start_i held high; inputs change mid-block and must only affect the next block.
        ka = rand_key(); pa = rand_64(); ca = present_enc(pa, ka);
        kb = rand_key(); pb = rand_64(); cb = present_enc(pb, kb);
        if (kb == ka) kb = ~ka;
        if (kb == ~ka) cb = present_enc(pb, kb);
        key_i = ka; ct_i = ca; start_i = 1'b1;
        n_done = 0; done_at = 0; acc = 1'b0; pt_cap = '0;
        for (int cy = 1; cy <= 100; cy++) begin
            @(posedge clk); #1;
            if (cy == 20) begin key_i = kb; ct_i = cb; end
            if (done_at > 0 && cy == done_at + 1) acc = (ready_o === 1'b0);
            if (done_o === 1'b1) begin n_done++; pt_cap = pt_o; done_at = cy; end
        end
        start_i = 1'b0;
        chk("hold.done_count", 80'(n_done), 80'(1));
        chk("hold.done_at", 80'(done_at), 80'(exp_lat(ka) + 1));
        chk("hold.pt", 80'(pt_cap), 80'(pa));
        chk("hold.accept_next", 80'(acc), 80'(1));
        m_vld = 1'b1; m_key = ka;
        latb = exp_lat(kb);
        c = 100;
        while (done_o !== 1'b1 && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        chk("hold.second_at", 80'(c), 80'(done_at + 1 + latb));
        chk("hold.second_pt", 80'(pt_o), 80'(pb));
        m_vld = 1'b1; m_key = kb;
        @(posedge clk); #1;

        // Reset 40 cycles into a full-length block.
        kr = rand_key(); if (kr == m_key) kr = ~kr;
        pr = rand_64(); cr = present_enc(pr, kr);
        key_i = kr; ct_i = cr; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort.busy", 80'(ready_o), 80'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_vld = 1'b0;
        chk("abort.done", 80'(done_o), 80'(0));
        chk("abort.ready", 80'(ready_o), 80'(1));
        chk("abort.pt", 80'(pt_o), 80'(0));
        run_block("abort.fresh", kr, cr, pr);

        // Random blocks; odd iterations reuse the previous key.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) kr = rand_key();
            pr = rand_64();
            cr = present_enc(pr, kr);
            run_block($sformatf("rnd%0d", i), kr, cr, pr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
